mem_port_scheduler: RTL and testbench
=====================================

# mem_port_scheduler

Shares the single backing-memory port between two requesters: line-sized refill/write-back traffic from the L2 cache, and word-sized uncached I/O accesses. It sits between `l2_cache`/the uncached I/O path and `Memory`. It grants one request at a time using round-robin priority and holds that request on the memory port until the memory completes it. It then returns the response to the owning requester, and a memory timeout terminates a request that gets no response.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `LINE_W`, 128, memory/L2 line width in bits (power of two, ≥ 64)
- `WORD_W`, 32, I/O word width (fixed at 32)
- `TIMEOUT_CYC`, 1024, max cycles waiting for `mem_ready_i`; 0 disables timeout (16-bit counter)

Ports:
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  reset; asynchronous, active-high
- `l2_req_valid_i`  in  1  L2 request; held until `l2_done_o`
- `l2_req_rw_i`  in  1  1 = write, 0 = read
- `l2_req_addr_i`  in  ADDR_W  line address; low log2(LINE_W/8) bits ignored
- `l2_req_wdata_i`  in  LINE_W  write line
- `l2_done_o`  out  1  one-cycle completion pulse
- `l2_rdata_o`  out  LINE_W  read line; valid while `l2_done_o`
- `io_req_valid_i`  in  1  I/O request; held until `io_done_o`
- `io_req_rw_i`  in  1  1 = write
- `io_req_addr_i`  in  ADDR_W  byte address; bits [1:0] ignored
- `io_req_wdata_i`  in  WORD_W  write word
- `io_req_be_i`  in  4  byte enables
- `io_done_o`  out  1  one-cycle completion pulse
- `io_rdata_o`  out  WORD_W  read word; valid while `io_done_o`
- `mem_valid_o`  out  1  memory request active
- `mem_rw_o`  out  1  1 = write
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_wdata_o`  out  LINE_W  write data
- `mem_be_o`  out  LINE_W/8  byte enables
- `mem_ready_i`  in  1  memory completion; single-cycle pulse
- `mem_rdata_i`  in  LINE_W  read data; valid with `mem_ready_i`
- `timeout_o`  out  1  sticky: a request timed out

## Operation
- FSM has three states.
  - IDLE: arbitrate valid requests.
  - BUSY: drive the memory port and wait for `mem_ready_i`.
  - RESP: pulse `done` to the owner, then return to IDLE.
- Arbitration, evaluated in IDLE only:
  - Only one requester valid: grant it.
  - Both valid: grant L2 if `rr_q`=0, otherwise grant I/O.
  - After any grant, `rr_q` points to the other requester. Reset value of `rr_q` is 0.
- Latching: at grant, rw/addr/wdata/be and an owner bit are latched. Later changes to the requester's inputs are ignored until RESP.
- L2 grant mapping:
  - `mem_addr_o` = addr with line-offset bits cleared.
  - `mem_be_o` = all ones.
  - `mem_wdata_o` = line.
- I/O grant mapping:
  - `mem_addr_o` = full addr with bits [1:0] cleared.
  - Lane = addr[log2(LINE_W/8)-1:2].
  - `mem_wdata_o` = the word replicated into every lane.
  - `mem_be_o` = `io_req_be_i` shifted to the lane; all other bits 0.
- Read data:
  - L2 reads: the full `mem_rdata_i` line is captured into `l2_rdata_o`.
  - I/O reads: only the selected lane is captured into `io_rdata_o`.
  - Writes: rdata outputs hold their previous value.
- Timeout:
  - The counter clears on entering BUSY and increments each BUSY cycle without `mem_ready_i`.
  - At TIMEOUT_CYC it drops `mem_valid_o` and goes to RESP with rdata = 0.
  - `timeout_o` is set and remains set until reset.
- Reset while in any state:
  - FSM goes to IDLE and the in-flight request is abandoned (the requester reissues).
  - `rr_q`, counter and `timeout_o` clear.

## Timing
- Reset values: every output is 0, FSM is IDLE.
- Request with valid high at edge N (FSM in IDLE):
  - Edge N: grant.
  - From N+1: `mem_valid_o` = 1 and stays 1 until the edge where `mem_ready_i` = 1.
- `mem_ready_i` high in the first BUSY cycle gives the minimum latency:
  - `done` is high in cycle N+2.
  - FSM is back in IDLE at N+3.
  - Back-to-back grant rate is at most one per 3 cycles.
- `done` is a single cycle; rdata is registered and remains stable after `done` until the next capture.
- Requester valid may remain high during the `done` cycle. It must be low at the following edge unless a new request is intended, because IDLE resamples it.
- Valid dropped before `done` is a protocol violation; the scheduler still completes and pulses `done`.
- `mem_ready_i` outside BUSY is ignored.

## Configuration
- `MEM_SCHED_STATS_EN` defined adds three 32-bit output ports, each cleared by reset and wrapping at 2^32:
  - `l2_grants_o`: increments on each L2 grant.
  - `io_grants_o`: increments on each I/O grant.
  - `busy_cycles_o`: increments each cycle the FSM is not IDLE.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- L2 read, addr 0x0000_1234, `mem_ready_i` on the first BUSY cycle:
  - `mem_addr_o`=0x0000_1230 and `mem_be_o`=0xFFFF at N+1.
  - `l2_done_o` at N+2 with the captured line.
- I/O write, addr 0x0000_7008, be 0x3, wdata 0xAABBCCDD (LINE_W=128):
  - `mem_be_o`=0x0300.
  - `mem_wdata_o`=0xAABBCCDD in all four lanes.
  - `io_done_o` after ready.
- Both requesters valid continuously for 6 grants from reset:
  - Grant order L2, IO, L2, IO, L2, IO.
  - No requester waits more than one transaction.
- TIMEOUT_CYC=4, `mem_ready_i` held low:
  - `mem_valid_o` high for exactly 4 cycles.
  - `done` pulses with rdata=0.
  - `timeout_o`=1 and stays 1.
- `rst_i` asserted mid-BUSY:
  - All outputs go to 0 immediately.
  - After release, a new I/O request is granted normally with `rr_q`=0 behaviour.
- With `MEM_SCHED_STATS_EN`, 3 L2 reads and 2 I/O reads, each with 1-cycle memory latency:
  - `l2_grants_o`=3, `io_grants_o`=2, `busy_cycles_o`=10.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler sharing one memory port between L2 line traffic and uncached I/O words.
// Define MEM_SCHED_STATS_EN to add grant and busy-cycle counter outputs.
module mem_port_scheduler #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                l2_req_valid_i,
  input  logic                l2_req_rw_i,
  input  logic [ADDR_W-1:0]   l2_req_addr_i,
  input  logic [LINE_W-1:0]   l2_req_wdata_i,
  output logic                l2_done_o,
  output logic [LINE_W-1:0]   l2_rdata_o,
  input  logic                io_req_valid_i,
  input  logic                io_req_rw_i,
  input  logic [ADDR_W-1:0]   io_req_addr_i,
  input  logic [WORD_W-1:0]   io_req_wdata_i,
  input  logic [3:0]          io_req_be_i,
  output logic                io_done_o,
  output logic [WORD_W-1:0]   io_rdata_o,
  output logic                mem_valid_o,
  output logic                mem_rw_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_wdata_o,
  output logic [LINE_W/8-1:0] mem_be_o,
  input  logic                mem_ready_i,
  input  logic [LINE_W-1:0]   mem_rdata_i,
`ifdef MEM_SCHED_STATS_EN
  output logic [31:0]         l2_grants_o,
  output logic [31:0]         io_grants_o,
  output logic [31:0]         busy_cycles_o,
`endif
  output logic                timeout_o
);

  localparam int BE_W   = LINE_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int LANES  = LINE_W / WORD_W;
  localparam int LANE_W = OFF_W - 2;
  localparam logic [15:0] TO_LAST = (TIMEOUT_CYC == 0) ? 16'd0 : 16'(TIMEOUT_CYC - 1);
  localparam logic TO_EN = (TIMEOUT_CYC != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic              r_rr;
  logic              r_owner_io;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [LANE_W-1:0] r_lane;
  logic [15:0]       r_cnt;
  logic              r_timeout;
  logic [LINE_W-1:0] r_l2_rdata;
  logic [WORD_W-1:0] r_io_rdata;

  logic              w_idle;
  logic              w_grant_l2;
  logic              w_grant_io;
  logic              w_to_hit;
  logic [ADDR_W-1:0] w_l2_addr;
  logic [ADDR_W-1:0] w_io_addr;
  logic [LANE_W-1:0] w_io_lane;
  logic [BE_W-1:0]   w_io_be;
  logic [LINE_W-1:0] w_io_wdata;
  logic [WORD_W-1:0] w_lane_rdata;
  logic              w_unused;

  // Arbitration: a lone requester always wins; on contention r_rr picks (0 = L2, 1 = I/O)
  assign w_idle     = (r_state == S_IDLE);
  assign w_grant_l2 = w_idle && l2_req_valid_i && (!io_req_valid_i || !r_rr);
  assign w_grant_io = w_idle && io_req_valid_i && (!l2_req_valid_i || r_rr);
  assign w_to_hit   = TO_EN && (r_cnt == TO_LAST);

  assign w_l2_addr    = {l2_req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_io_addr    = {io_req_addr_i[ADDR_W-1:2], 2'b00};
  assign w_io_lane    = io_req_addr_i[OFF_W-1:2];
  assign w_io_be      = BE_W'(io_req_be_i) << {w_io_lane, 2'b00};
  assign w_io_wdata   = {LANES{io_req_wdata_i}};
  assign w_lane_rdata = mem_rdata_i[int'(r_lane)*WORD_W +: WORD_W];
  assign w_unused     = ^{io_req_addr_i[1:0], l2_req_addr_i[OFF_W-1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_rr       <= 1'b0;
      r_owner_io <= 1'b0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_lane     <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_l2_rdata <= '0;
      r_io_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_l2) begin
            r_state    <= S_BUSY;
            r_rr       <= 1'b1;
            r_owner_io <= 1'b0;
            r_rw       <= l2_req_rw_i;
            r_addr     <= w_l2_addr;
            r_wdata    <= l2_req_wdata_i;
            r_be       <= '1;
            r_lane     <= '0;
            r_cnt      <= '0;
          end else if (w_grant_io) begin
            r_state    <= S_BUSY;
            r_rr       <= 1'b0;
            r_owner_io <= 1'b1;
            r_rw       <= io_req_rw_i;
            r_addr     <= w_io_addr;
            r_wdata    <= w_io_wdata;
            r_be       <= w_io_be;
            r_lane     <= w_io_lane;
            r_cnt      <= '0;
          end
        end
        // A ready pulse in the same cycle as the timeout limit still completes normally
        S_BUSY: begin
          if (mem_ready_i) begin
            r_state <= S_RESP;
            if (!r_rw) begin
              if (r_owner_io) r_io_rdata <= w_lane_rdata;
              else            r_l2_rdata <= mem_rdata_i;
            end
          end else if (w_to_hit) begin
            r_state   <= S_RESP;
            r_timeout <= 1'b1;
            if (r_owner_io) r_io_rdata <= '0;
            else            r_l2_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_valid_o = (r_state == S_BUSY);
  assign mem_rw_o    = r_rw;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_be_o    = r_be;
  assign l2_done_o   = (r_state == S_RESP) && !r_owner_io;
  assign io_done_o   = (r_state == S_RESP) && r_owner_io;
  assign l2_rdata_o  = r_l2_rdata;
  assign io_rdata_o  = r_io_rdata;
  assign timeout_o   = r_timeout;

`ifdef MEM_SCHED_STATS_EN
  logic [31:0] r_l2_grants;
  logic [31:0] r_io_grants;
  logic [31:0] r_busy_cycles;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_l2_grants   <= '0;
      r_io_grants   <= '0;
      r_busy_cycles <= '0;
    end else begin
      if (w_grant_l2) r_l2_grants   <= r_l2_grants + 32'd1;
      if (w_grant_io) r_io_grants   <= r_io_grants + 32'd1;
      if (!w_idle)    r_busy_cycles <= r_busy_cycles + 32'd1;
    end
  end

  assign l2_grants_o   = r_l2_grants;
  assign io_grants_o   = r_io_grants;
  assign busy_cycles_o = r_busy_cycles;
`endif

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed and randomized bench for mem_port_scheduler (LINE_W=128, TIMEOUT_CYC=4).
`timescale 1ns/1ps
module tb_mem_port_scheduler;
  localparam int TO = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         l2_req_valid_i, l2_req_rw_i;
  logic [31:0]  l2_req_addr_i;
  logic [127:0] l2_req_wdata_i;
  logic         l2_done_o;
  logic [127:0] l2_rdata_o;
  logic         io_req_valid_i, io_req_rw_i;
  logic [31:0]  io_req_addr_i, io_req_wdata_i;
  logic [3:0]   io_req_be_i;
  logic         io_done_o;
  logic [31:0]  io_rdata_o;
  logic         mem_valid_o, mem_rw_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [15:0]  mem_be_o;
  logic         mem_ready_i;
  logic [127:0] mem_rdata_i;
  logic         timeout_o;
`ifdef MEM_SCHED_STATS_EN
  logic [31:0]  l2_grants_o, io_grants_o, busy_cycles_o;
`endif

  mem_port_scheduler #(.ADDR_W(32), .LINE_W(128), .WORD_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .l2_req_valid_i(l2_req_valid_i), .l2_req_rw_i(l2_req_rw_i),
    .l2_req_addr_i(l2_req_addr_i), .l2_req_wdata_i(l2_req_wdata_i),
    .l2_done_o(l2_done_o), .l2_rdata_o(l2_rdata_o),
    .io_req_valid_i(io_req_valid_i), .io_req_rw_i(io_req_rw_i),
    .io_req_addr_i(io_req_addr_i), .io_req_wdata_i(io_req_wdata_i),
    .io_req_be_i(io_req_be_i), .io_done_o(io_done_o), .io_rdata_o(io_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
`ifdef MEM_SCHED_STATS_EN
    .l2_grants_o(l2_grants_o), .io_grants_o(io_grants_o), .busy_cycles_o(busy_cycles_o),
`endif
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: preference pointer, sticky timeout, last delivered read data
  bit           m_rr;
  bit           m_timeout;
  logic [127:0] m_l2_rdata;
  logic [31:0]  m_io_rdata;

  // Outstanding requests the bench is holding on each requester
  bit           p_l2, p_l2_rw;
  logic [31:0]  p_l2_addr;
  logic [127:0] p_l2_wdata;
  bit           p_io, p_io_rw;
  logic [31:0]  p_io_addr, p_io_wdata;
  logic [3:0]   p_io_be;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_rr = 1'b0; m_timeout = 1'b0; m_l2_rdata = '0; m_io_rdata = '0;
    p_l2 = 1'b0; p_io = 1'b0;
  endtask

  task automatic new_l2(input bit rw, input logic [31:0] addr, input logic [127:0] wd);
    p_l2 = 1'b1; p_l2_rw = rw; p_l2_addr = addr; p_l2_wdata = wd;
  endtask

  task automatic new_io(input bit rw, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    p_io = 1'b1; p_io_rw = rw; p_io_addr = addr; p_io_wdata = wd; p_io_be = be;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_valid"}, mem_valid_o, 0);
    chk({tag, "_mem_rw"}, mem_rw_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_mem_be"}, mem_be_o, 0);
    chk({tag, "_l2_done"}, l2_done_o, 0);
    chk({tag, "_io_done"}, io_done_o, 0);
    chk({tag, "_l2_rdata"}, l2_rdata_o, 0);
    chk({tag, "_io_rdata"}, io_rdata_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
  endtask

  // One full transaction starting at a negedge with the FSM idle; lat = BUSY cycles before ready
  task automatic do_txn(input int lat, output bit won_io);
    bit           w_io, timed, e_rw;
    logic [31:0]  e_addr;
    logic [15:0]  e_be;
    logic [127:0] e_wdata, line;
    int           lane, vcnt;
    l2_req_valid_i = p_l2; l2_req_rw_i = p_l2_rw; l2_req_addr_i = p_l2_addr; l2_req_wdata_i = p_l2_wdata;
    io_req_valid_i = p_io; io_req_rw_i = p_io_rw; io_req_addr_i = p_io_addr;
    io_req_wdata_i = p_io_wdata; io_req_be_i = p_io_be;
    mem_ready_i = 1'($urandom_range(1));
    mem_rdata_i = rnd128();
    line = '0;
    w_io = (p_l2 && p_io) ? m_rr : p_io;
    m_rr = !w_io;
    if (w_io) begin
      lane    = int'(p_io_addr % 16) / 4;
      e_addr  = p_io_addr - (p_io_addr % 4);
      e_be    = 16'(p_io_be) * 16'(1 << (4 * lane));
      e_wdata = {4{p_io_wdata}};
      e_rw    = p_io_rw;
    end else begin
      lane    = 0;
      e_addr  = p_l2_addr - (p_l2_addr % 16);
      e_be    = 16'hFFFF;
      e_wdata = p_l2_wdata;
      e_rw    = p_l2_rw;
    end
    @(posedge clk_i); @(negedge clk_i);
    mem_ready_i = 1'b0;
    chk("busy_valid", mem_valid_o, 1);
    chk("busy_addr", mem_addr_o, e_addr);
    chk("busy_be", mem_be_o, e_be);
    chk("busy_wdata", mem_wdata_o, e_wdata);
    chk("busy_rw", mem_rw_o, e_rw);
    if (w_io) begin
      io_req_addr_i = $urandom; io_req_wdata_i = $urandom; io_req_be_i = 4'($urandom); io_req_rw_i = !p_io_rw;
    end else begin
      l2_req_addr_i = $urandom; l2_req_wdata_i = rnd128(); l2_req_rw_i = !p_l2_rw;
    end
    vcnt  = 0;
    timed = (lat >= TO);
    for (int c = 0; c < 64; c++) begin
      if (mem_valid_o) vcnt++;
      if (c == lat) begin
        line = rnd128();
        mem_ready_i = 1'b1;
        mem_rdata_i = line;
      end
      @(posedge clk_i); @(negedge clk_i);
      mem_ready_i = 1'b0;
      mem_rdata_i = rnd128();
      if (c == lat || c == TO - 1) break;
    end
    if (timed) begin
      m_timeout = 1'b1;
      if (w_io) m_io_rdata = '0; else m_l2_rdata = '0;
    end else if (!e_rw) begin
      if (w_io) m_io_rdata = line[32*lane +: 32]; else m_l2_rdata = line;
    end
    chk("valid_cycles", vcnt, timed ? TO : lat + 1);
    chk("resp_l2_done", l2_done_o, !w_io);
    chk("resp_io_done", io_done_o, w_io);
    chk("resp_valid", mem_valid_o, 0);
    chk("resp_addr_held", mem_addr_o, e_addr);
    chk("resp_l2_rdata", l2_rdata_o, m_l2_rdata);
    chk("resp_io_rdata", io_rdata_o, m_io_rdata);
    chk("resp_timeout", timeout_o, m_timeout);
    if (w_io) p_io = 1'b0; else p_l2 = 1'b0;
    l2_req_valid_i = p_l2;
    io_req_valid_i = p_io;
    won_io = w_io;
    @(posedge clk_i); @(negedge clk_i);
    chk("idle_l2_done", l2_done_o, 0);
    chk("idle_io_done", io_done_o, 0);
    chk("idle_l2_rdata", l2_rdata_o, m_l2_rdata);
    chk("idle_io_rdata", io_rdata_o, m_io_rdata);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    rst_i = 1'b1;
    l2_req_valid_i = 0; l2_req_rw_i = 0; l2_req_addr_i = 0; l2_req_wdata_i = 0;
    io_req_valid_i = 0; io_req_rw_i = 0; io_req_addr_i = 0; io_req_wdata_i = 0; io_req_be_i = 0;
    mem_ready_i = 0; mem_rdata_i = 0;
    model_reset();
    @(negedge clk_i); @(negedge clk_i);
    chk_zero("in_reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_zero("after_reset");

    // L2 read of 0x1234 with ready on the first BUSY cycle
    new_l2(1'b0, 32'h0000_1234, rnd128());
    do_txn(0, w);
    chk("l2_read_owner", w, 0);

    // I/O write into lane 2
    new_io(1'b1, 32'h0000_7008, 32'hAABBCCDD, 4'h3);
    do_txn(0, w);
    chk("io_write_owner", w, 1);

    // Both requesters continuously valid from reset: strict alternation
    rst_i = 1'b1; @(negedge clk_i); rst_i = 1'b0; model_reset();
    new_l2(1'($urandom), $urandom, rnd128());
    new_io(1'($urandom), $urandom, $urandom, 4'($urandom));
    for (int i = 0; i < 6; i++) begin
      do_txn(int'($urandom_range(2)), w);
      chk("rr_order", w, (i % 2) == 1);
      if (w) new_io(1'($urandom), $urandom, $urandom, 4'($urandom));
      else   new_l2(1'($urandom), $urandom, rnd128());
    end
    while (p_l2 || p_io) do_txn(0, w);

    // Timeout with ready held low, then timeout_o must stay set
    new_io(1'b0, 32'h0000_0104, 32'h0, 4'hF);
    do_txn(1000, w);
    new_l2(1'b0, 32'h0000_2000, rnd128());
    do_txn(1, w);
    chk("timeout_sticky", timeout_o, 1);

    // Randomized traffic with random memory latency (some beyond the timeout)
    for (int i = 0; i < 80; i++) begin
      if (!p_l2 && ($urandom_range(1) == 1)) new_l2(1'($urandom), $urandom, rnd128());
      if (!p_io && ($urandom_range(1) == 1)) new_io(1'($urandom), $urandom, $urandom, 4'($urandom));
      if (p_l2 || p_io) begin
        do_txn(int'($urandom_range(5)), w);
      end else begin
        mem_ready_i = 1'($urandom_range(1));
        mem_rdata_i = rnd128();
        @(posedge clk_i); @(negedge clk_i);
        mem_ready_i = 1'b0;
        chk("idle_no_valid", mem_valid_o, 0);
        chk("idle_rdata_l2", l2_rdata_o, m_l2_rdata);
        chk("idle_rdata_io", io_rdata_o, m_io_rdata);
      end
    end
    while (p_l2 || p_io) do_txn(0, w);

    // Reset in the middle of an L2 BUSY phase (leaves the pointer favouring I/O beforehand)
    l2_req_valid_i = 1'b1; l2_req_rw_i = 1'b0; l2_req_addr_i = 32'h0000_3330;
    io_req_valid_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    chk("mid_busy_valid", mem_valid_o, 1);
    rst_i = 1'b1;
    #1;
    chk_zero("mid_busy_reset");
    l2_req_valid_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    new_l2(1'b0, 32'h0000_4440, rnd128());
    new_io(1'b0, 32'h0000_500C, 32'h0, 4'hF);
    do_txn(0, w);
    chk("rr_after_reset_first", w, 0);
    do_txn(0, w);
    chk("io_after_reset", w, 1);

`ifdef MEM_SCHED_STATS_EN
    rst_i = 1'b1; @(negedge clk_i); rst_i = 1'b0; model_reset();
    for (int i = 0; i < 3; i++) begin
      new_l2(1'b0, $urandom, rnd128());
      do_txn(0, w);
    end
    for (int i = 0; i < 2; i++) begin
      new_io(1'b0, $urandom, $urandom, 4'hF);
      do_txn(0, w);
    end
    chk("stats_l2_grants", l2_grants_o, 3);
    chk("stats_io_grants", io_grants_o, 2);
    chk("stats_busy_cycles", busy_cycles_o, 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
